// File: rtl/uart_rx_oversample.sv
// 8N1 UART receiver, OVERSAMPLE x baud_tick oversampling, mid-bit sampling; registered ready/error pulses.
// Define UART_RX_PARITY_EN to insert a parity bit (sense set by PARITY_ODD) between data and stop.
module uart_rx_oversample #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic                 rx_wire,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_data_ready,
  output logic                 rx_error
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0 || DATA_BITS < 5 || DATA_BITS > 8 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
    $error("uart_rx_oversample: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t               state_q, state_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 ready_q, ready_d;
  logic                 error_q, error_d;
  logic                 sync1_q, sync2_q;
  logic                 rx_s;
`ifdef UART_RX_PARITY_EN
  localparam logic PAR_SENSE = (PARITY_ODD != 0);
  logic                 par_err_q, par_err_d;
`endif

  assign rx_s = sync2_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      ready_q    <= 1'b0;
      error_q    <= 1'b0;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
`ifdef UART_RX_PARITY_EN
      par_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      ready_q    <= ready_d;
      error_q    <= error_d;
      sync1_q    <= rx_wire;
      sync2_q    <= sync1_q;
`ifdef UART_RX_PARITY_EN
      par_err_q  <= par_err_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    ready_d    = 1'b0;
    error_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d  = par_err_q;
`endif
    if (baud_tick) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_s) begin
            state_d    = S_START;
            tick_cnt_d = '0;
          end
        end
        S_START: begin
          if (tick_cnt_q == HALF_M1) begin
            // A high line at mid start bit is a glitch, not a frame.
            if (!rx_s) begin
              state_d    = S_DATA;
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
        S_DATA: begin
          if (tick_cnt_q == FULL_M1) begin
            shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
            bit_cnt_d  = bit_cnt_q + BW'(1);
            tick_cnt_d = '0;
            if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (tick_cnt_q == FULL_M1) begin
            par_err_d  = rx_s ^ (^shift_q) ^ PAR_SENSE;
            tick_cnt_d = '0;
            state_d    = S_STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
`endif
        S_STOP: begin
          if (tick_cnt_q == FULL_M1) begin
            // Leave at mid-stop so an immediately following start edge is caught.
            tick_cnt_d = '0;
            if (!rx_s) begin
              error_d = 1'b1;
              state_d = S_BREAK;
            end
`ifdef UART_RX_PARITY_EN
            else if (par_err_q) begin
              error_d = 1'b1;
              state_d = S_IDLE;
            end
`endif
            else begin
              data_d  = shift_q;
              ready_d = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
        S_BREAK: begin
          if (rx_s) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign rx_data       = data_q;
  assign rx_data_ready = ready_q;
  assign rx_error      = error_q;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Bench for uart_rx_oversample: directed scenarios plus random frames scored against a frame-level model.
module tb_uart_rx_oversample;

  localparam int OS       = 16;
  localparam int DB       = 8;
  localparam int PODD     = 0;
  localparam int TICK_DIV = 4;
  localparam int BIT_CLKS = OS * TICK_DIV;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          baud_tick = 1'b0;
  logic          rx_wire = 1'b1;
  logic [DB-1:0] rx_data;
  logic          rx_data_ready;
  logic          rx_error;

  int checks = 0;
  int errors = 0;

  // Event log filled by the monitor; tasks compare deltas against their own expectations.
  int            ready_cnt = 0;
  int            err_cnt = 0;
  int            wide_cnt = 0;
  int            overlap_cnt = 0;
  logic          ready_prev = 1'b0;
  logic          err_prev = 1'b0;
  logic [DB-1:0] got_q[$];
  logic [DB-1:0] model_data = '0;

  uart_rx_oversample #(
    .OVERSAMPLE(OS),
    .DATA_BITS (DB),
    .PARITY_ODD(PODD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .baud_tick    (baud_tick),
    .rx_wire      (rx_wire),
    .rx_data      (rx_data),
    .rx_data_ready(rx_data_ready),
    .rx_error     (rx_error)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      baud_tick = 1'b1;
      @(negedge clk);
      baud_tick = 1'b0;
      repeat (TICK_DIV - 2) @(negedge clk);
    end
  end

  always @(negedge clk) begin
    if (rx_data_ready === 1'b1) begin
      ready_cnt++;
      got_q.push_back(rx_data);
      if (ready_prev) wide_cnt++;
    end
    if (rx_error === 1'b1) begin
      err_cnt++;
      if (err_prev) wide_cnt++;
      if (rx_data_ready === 1'b1) overlap_cnt++;
    end
    ready_prev = (rx_data_ready === 1'b1);
    err_prev   = (rx_error === 1'b1);
  end

  task automatic drive_bit(input logic b);
    rx_wire = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic stop_bit, input logic flip_par);
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(d[i]);
    if (PAR_EN) drive_bit((^d) ^ (PODD != 0) ^ flip_par);
    drive_bit(stop_bit);
    rx_wire = 1'b1;
  endtask

  task automatic idle(input int n);
    rx_wire = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    int r0, e0;
    rst_n   = 1'b0;
    rx_wire = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (rx_data !== 8'h00) begin
      errors++; $display("FAIL reset_data got %h want 00", rx_data);
    end
    checks++;
    if (rx_data_ready !== 1'b0 || rx_error !== 1'b0) begin
      errors++; $display("FAIL reset_pulses got ready=%b error=%b want 0 0", rx_data_ready, rx_error);
    end
    rst_n = 1'b1;
    r0 = ready_cnt; e0 = err_cnt;
    idle(200);
    model_data = '0;
    checks++;
    if (rx_data !== model_data) begin
      errors++; $display("FAIL idle_data got %h want %h", rx_data, model_data);
    end
    checks++;
    if (ready_cnt - r0 !== 0) begin
      errors++; $display("FAIL idle_ready got %0d want 0", ready_cnt - r0);
    end
    checks++;
    if (err_cnt - e0 !== 0) begin
      errors++; $display("FAIL idle_error got %0d want 0", err_cnt - e0);
    end
  endtask

  task automatic test_single();
    int r0, e0, n0;
    r0 = ready_cnt; e0 = err_cnt; n0 = got_q.size();
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(8);
    model_data = 8'hA5;
    checks++;
    if (ready_cnt - r0 !== 1) begin
      errors++; $display("FAIL single_ready_count got %0d want 1", ready_cnt - r0);
    end
    checks++;
    if (got_q.size() <= n0 || got_q[n0] !== 8'hA5) begin
      errors++; $display("FAIL single_pulse_data got %h want a5", (got_q.size() > n0) ? got_q[n0] : 8'hxx);
    end
    checks++;
    if (rx_data !== model_data) begin
      errors++; $display("FAIL single_held_data got %h want %h", rx_data, model_data);
    end
    checks++;
    if (err_cnt - e0 !== 0) begin
      errors++; $display("FAIL single_error got %0d want 0", err_cnt - e0);
    end
  endtask

  task automatic test_back_to_back();
    int r0, n0;
    r0 = ready_cnt; n0 = got_q.size();
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle(8);
    model_data = 8'hFF;
    checks++;
    if (ready_cnt - r0 !== 2) begin
      errors++; $display("FAIL b2b_count got %0d want 2", ready_cnt - r0);
    end
    checks++;
    if (got_q.size() < n0 + 2 || got_q[n0] !== 8'h00 || got_q[n0+1] !== 8'hFF) begin
      errors++; $display("FAIL b2b_data got %0d bytes want 00 then ff", got_q.size() - n0);
    end
    checks++;
    if (rx_data !== model_data) begin
      errors++; $display("FAIL b2b_held got %h want %h", rx_data, model_data);
    end
  endtask

  task automatic test_framing();
    int r0, e0, n0;
    r0 = ready_cnt; e0 = err_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(2 * BIT_CLKS);
    checks++;
    if (err_cnt - e0 !== 1) begin
      errors++; $display("FAIL frame_err_count got %0d want 1", err_cnt - e0);
    end
    checks++;
    if (ready_cnt - r0 !== 0 || rx_data !== model_data) begin
      errors++; $display("FAIL frame_no_update got ready=%0d data=%h want 0 %h", ready_cnt - r0, rx_data, model_data);
    end
    n0 = got_q.size();
    send_frame(8'h55, 1'b1, 1'b0);
    idle(8);
    model_data = 8'h55;
    checks++;
    if (got_q.size() != n0 + 1 || got_q[n0] !== 8'h55) begin
      errors++; $display("FAIL frame_recover got %0d bytes want one 55", got_q.size() - n0);
    end
    checks++;
    if (err_cnt - e0 !== 1) begin
      errors++; $display("FAIL frame_recover_err got %0d want 1", err_cnt - e0);
    end
  endtask

  task automatic test_break();
    int r0, e0;
    r0 = ready_cnt; e0 = err_cnt;
    rx_wire = 1'b0;
    repeat (30 * BIT_CLKS) @(negedge clk);
    idle(2 * BIT_CLKS);
    checks++;
    if (err_cnt - e0 !== 1) begin
      errors++; $display("FAIL break_err_count got %0d want 1", err_cnt - e0);
    end
    checks++;
    if (ready_cnt - r0 !== 0 || rx_data !== model_data) begin
      errors++; $display("FAIL break_no_ready got ready=%0d data=%h want 0 %h", ready_cnt - r0, rx_data, model_data);
    end
  endtask

  task automatic test_glitch();
    int r0, e0, n0;
    logic [DB-1:0] d;
    r0 = ready_cnt; e0 = err_cnt;
    rx_wire = 1'b0;
    repeat (4 * TICK_DIV) @(negedge clk);
    idle(2 * BIT_CLKS);
    checks++;
    if (ready_cnt - r0 !== 0 || err_cnt - e0 !== 0) begin
      errors++; $display("FAIL glitch_quiet got ready=%0d error=%0d want 0 0", ready_cnt - r0, err_cnt - e0);
    end
    n0 = got_q.size();
    d = DB'($urandom_range(0, (1 << DB) - 1));
    send_frame(d, 1'b1, 1'b0);
    idle(8);
    model_data = d;
    checks++;
    if (got_q.size() != n0 + 1 || got_q[n0] !== d) begin
      errors++; $display("FAIL glitch_then_frame got %0d bytes want one %h", got_q.size() - n0, d);
    end
  endtask

  task automatic test_reset_mid();
    int r0, e0, n0;
    r0 = ready_cnt; e0 = err_cnt;
    drive_bit(1'b0);
    drive_bit(1'b1);
    rx_wire = 1'b0;
    repeat (BIT_CLKS / 2) @(negedge clk);
    rst_n   = 1'b0;
    rx_wire = 1'b1;
    @(negedge clk);
    model_data = '0;
    checks++;
    if (rx_data !== model_data || rx_data_ready !== 1'b0 || rx_error !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs got data=%h ready=%b error=%b want 00 0 0", rx_data, rx_data_ready, rx_error);
    end
    rst_n = 1'b1;
    idle(20 * BIT_CLKS);
    checks++;
    if (ready_cnt - r0 !== 0 || err_cnt - e0 !== 0) begin
      errors++; $display("FAIL midreset_no_pulse got ready=%0d error=%0d want 0 0", ready_cnt - r0, err_cnt - e0);
    end
    n0 = got_q.size();
    send_frame(8'h81, 1'b1, 1'b0);
    idle(8);
    model_data = 8'h81;
    checks++;
    if (got_q.size() != n0 + 1 || got_q[n0] !== 8'h81 || rx_data !== model_data) begin
      errors++; $display("FAIL midreset_recover got %0d bytes data=%h want one 81", got_q.size() - n0, rx_data);
    end
  endtask

  task automatic test_random();
    int r0, e0, n0, exp_err, gap;
    logic [DB-1:0] exp_q[$];
    logic [DB-1:0] d;
    logic stop_ok, par_bad;
    r0 = ready_cnt; e0 = err_cnt; n0 = got_q.size(); exp_err = 0;
    for (int k = 0; k < 14; k++) begin
      d       = DB'($urandom_range(0, (1 << DB) - 1));
      stop_ok = ($urandom_range(0, 4) != 0);
      par_bad = PAR_EN && ($urandom_range(0, 3) == 0);
      send_frame(d, stop_ok, par_bad);
      if (stop_ok && !par_bad) begin
        exp_q.push_back(d);
        model_data = d;
      end else begin
        exp_err++;
      end
      gap = stop_ok ? $urandom_range(0, 30) : BIT_CLKS + $urandom_range(0, 30);
      idle(gap);
    end
    idle(8);
    checks++;
    if (ready_cnt - r0 !== exp_q.size()) begin
      errors++; $display("FAIL rand_ready_count got %0d want %0d", ready_cnt - r0, exp_q.size());
    end
    checks++;
    if (err_cnt - e0 !== exp_err) begin
      errors++; $display("FAIL rand_err_count got %0d want %0d", err_cnt - e0, exp_err);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q.size() <= n0 + i || got_q[n0+i] !== exp_q[i]) begin
        errors++; $display("FAIL rand_byte_%0d got %h want %h", i, (got_q.size() > n0 + i) ? got_q[n0+i] : 8'hxx, exp_q[i]);
      end
    end
    checks++;
    if (rx_data !== model_data) begin
      errors++; $display("FAIL rand_held got %h want %h", rx_data, model_data);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int r0, e0, n0;
    r0 = ready_cnt; e0 = err_cnt; n0 = got_q.size();
    send_frame(8'h07, 1'b1, 1'b0);
    idle(8);
    model_data = 8'h07;
    checks++;
    if (ready_cnt - r0 !== 1 || got_q.size() <= n0 || got_q[n0] !== 8'h07) begin
      errors++; $display("FAIL parity_good got ready=%0d want 1 with 07", ready_cnt - r0);
    end
    r0 = ready_cnt;
    send_frame(8'h07, 1'b1, 1'b1);
    idle(8);
    checks++;
    if (ready_cnt - r0 !== 0 || err_cnt - e0 !== 1) begin
      errors++; $display("FAIL parity_bad got ready=%0d error=%0d want 0 1", ready_cnt - r0, err_cnt - e0);
    end
    checks++;
    if (rx_data !== model_data) begin
      errors++; $display("FAIL parity_held got %h want %h", rx_data, model_data);
    end
  endtask
`endif

  task automatic test_pulse_shape();
    checks++;
    if (wide_cnt !== 0) begin
      errors++; $display("FAIL pulse_width got %0d wide pulses want 0", wide_cnt);
    end
    checks++;
    if (overlap_cnt !== 0) begin
      errors++; $display("FAIL pulse_overlap got %0d want 0", overlap_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_framing();
    test_break();
    test_glitch();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_random();
    test_pulse_shape();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
